// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg -- shared definitions for the multi-cycle CPU control unit.
// Holds the opcode map, the state codes shown on the debug display, the A-mux
// select codes and the bundle of datapath control strobes. The datapath and
// the benches import the same package so the encodings stay in one place.
// -----------------------------------------------------------------------------
package cu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_IN    = 3'b100,
        OP_JZ    = 3'b101,
        OP_JPOS  = 3'b110,
        OP_HALT  = 3'b111
    } opcode_e;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_IN     = 4'd7,
        S_INREL  = 4'd8,
        S_JZ     = 4'd9,
        S_JPOS   = 4'd10,
        S_HALT   = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ASEL_ALU   = 2'b00,
        ASEL_INPUT = 2'b01,
        ASEL_MEM   = 2'b10
    } asel_e;

    typedef struct packed {
        logic  ir_load;
        logic  jmp_mux;
        logic  pc_load;
        logic  meminst;
        logic  mem_wr;
        logic  a_load;
        logic  sub;
        asel_e asel;
        logic  halt;
    } ctrl_t;

    // Execute state that follows DECODE for each opcode.
    function automatic state_e exec_state(input opcode_e op);
        case (op)
            OP_LOAD:  return S_LOAD;
            OP_STORE: return S_STORE;
            OP_ADD:   return S_ADD;
            OP_SUB:   return S_SUB;
            OP_IN:    return S_IN;
            OP_JZ:    return S_JZ;
            OP_JPOS:  return S_JPOS;
            default:  return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// -----------------------------------------------------------------------------
// control_unit_if -- control-unit <-> datapath bundle.
//   IR, Aeq0, Apos : opcode and status flags from the datapath
//   Enter          : user input-ready level
//   IRload..Sub    : single-bit datapath controls
//   Asel           : A-mux select (see cu_pkg::asel_e)
//   Halt, State    : halted indicator and current state code for display
// master = control unit side, slave = datapath / environment side.
// -----------------------------------------------------------------------------
interface control_unit_if;
    logic [2:0] IR;
    logic       Aeq0;
    logic       Apos;
    logic       Enter;
    logic       IRload;
    logic       JMPmux;
    logic       PCload;
    logic       Meminst;
    logic       MemWr;
    logic       Aload;
    logic       Sub;
    logic [1:0] Asel;
    logic       Halt;
    logic [3:0] State;

    modport master (
        input  IR, Aeq0, Apos, Enter,
        output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
    );

    modport slave (
        output IR, Aeq0, Apos, Enter,
        input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
    );
endinterface

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit -- FSM sequencing FETCH / DECODE / execute for an 8-opcode
// accumulator CPU.
//   Clock : system clock, all state changes on the rising edge
//   Reset : synchronous, active-high; returns to START from any state
//   bus   : control_unit_if.master (opcode/flags/Enter in, controls out)
// Outputs are decoded from the state register; Aload in IN follows Enter and
// PCload in JZ/JPOS follows the flag sampled in that same cycle.
// -----------------------------------------------------------------------------
module control_unit
    import cu_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    control_unit_if.master   bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of its inputs.
    always_ff @(posedge Clock) begin
        if (Reset) state_q <= S_START;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output and the next state get a default before the case,
        // so no path leaves them unassigned and no latch is inferred.
        state_d = state_q;
        ctrl    = '0;

        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                ctrl.ir_load = 1'b1;
                ctrl.pc_load = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                ctrl.meminst = 1'b1;
                state_d      = exec_state(opcode_e'(bus.IR));
            end
            S_LOAD: begin
                ctrl.meminst = 1'b1;
                ctrl.a_load  = 1'b1;
                ctrl.asel    = ASEL_MEM;
                state_d      = S_FETCH;
            end
            S_STORE: begin
                ctrl.meminst = 1'b1;
                ctrl.mem_wr  = 1'b1;
                state_d      = S_FETCH;
            end
            S_ADD, S_SUB: begin
                ctrl.meminst = 1'b1;
                ctrl.a_load  = 1'b1;
                ctrl.asel    = ASEL_ALU;
                ctrl.sub     = (state_q == S_SUB);
                state_d      = S_FETCH;
            end
            S_IN: begin
                ctrl.asel   = ASEL_INPUT;
                ctrl.a_load = bus.Enter;
                if (bus.Enter) state_d = S_INREL;
            end
            // Wait for Enter to drop so one press loads exactly one value.
            S_INREL: begin
                if (!bus.Enter) state_d = S_FETCH;
            end
            S_JZ: begin
                ctrl.jmp_mux = 1'b1;
                ctrl.pc_load = bus.Aeq0;
                state_d      = S_FETCH;
            end
            S_JPOS: begin
                ctrl.jmp_mux = 1'b1;
                ctrl.pc_load = bus.Apos;
                state_d      = S_FETCH;
            end
            S_HALT:  ctrl.halt = 1'b1;
            default: state_d = S_START;
        endcase

        // Controls read quiet while Reset is high, even before the first edge
        // has loaded START and even if Enter is held during IN.
        if (Reset) ctrl = '0;
    end

    assign bus.IRload  = ctrl.ir_load;
    assign bus.JMPmux  = ctrl.jmp_mux;
    assign bus.PCload  = ctrl.pc_load;
    assign bus.Meminst = ctrl.meminst;
    assign bus.MemWr   = ctrl.mem_wr;
    assign bus.Aload   = ctrl.a_load;
    assign bus.Sub     = ctrl.sub;
    assign bus.Asel    = ctrl.asel;
    assign bus.Halt    = ctrl.halt;
    assign bus.State   = Reset ? S_START : state_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit -- self-checking bench for control_unit.
// Output word compared each cycle:
//   {IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel[1:0], Halt, State[3:0]}
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    control_unit_if cu_if();

    control_unit dut (
        .Clock (clk),
        .Reset (reset),
        .bus   (cu_if.master)
    );

    int vectors     = 0;
    int miscompares = 0;
    int ref_st      = 0;

    typedef struct {
        logic        rst;
        logic [2:0]  ir;
        logic        a0;
        logic        ap;
        logic        en;
        logic [13:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [13:0] w(input logic irl, input logic jmp, input logic pc,
                                      input logic mi, input logic mw, input logic al,
                                      input logic sb, input logic [1:0] as,
                                      input logic hl, input logic [3:0] st);
        return {irl, jmp, pc, mi, mw, al, sb, as, hl, st};
    endfunction

    function automatic logic [13:0] got_word();
        return {cu_if.IRload, cu_if.JMPmux, cu_if.PCload, cu_if.Meminst, cu_if.MemWr,
                cu_if.Aload, cu_if.Sub, cu_if.Asel, cu_if.Halt, cu_if.State};
    endfunction

    // Reference model: next state from the instruction-cycle rules.
    function automatic int ref_next(input int st, input logic rst, input logic [2:0] ir,
                                    input logic en);
        int exec_of_op [8] = '{3, 4, 5, 6, 7, 9, 10, 11};
        if (rst) return 0;
        case (st)
            0:       return 1;
            1:       return 2;
            2:       return exec_of_op[ir];
            7:       return en ? 8 : 7;
            8:       return en ? 8 : 1;
            11:      return 11;
            default: return 1;
        endcase
    endfunction

    // Reference model: per-state control table, then the input-dependent bits.
    function automatic logic [13:0] ref_out(input int st, input logic rst, input logic en,
                                            input logic a0, input logic ap);
        logic [9:0] tbl_ctl [12] = '{
            10'b0000000000, 10'b1010000000, 10'b0001000000, 10'b0001010100,
            10'b0001100000, 10'b0001010000, 10'b0001011000, 10'b0000000010,
            10'b0000000000, 10'b0100000000, 10'b0100000000, 10'b0000000001 };
        logic [9:0] c;
        if (rst) return 14'd0;
        c = tbl_ctl[st];
        if (st == 7)  c[4] = en;
        if (st == 9)  c[7] = a0;
        if (st == 10) c[7] = ap;
        return {c, 4'(st)};
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // One cycle: drive on the falling edge, compare, then let the rising edge
    // move both the DUT and the model.
    task automatic step(input logic rst, input logic [2:0] ir, input logic a0,
                        input logic ap, input logic en, input logic [13:0] exp,
                        input string name);
        @(negedge clk);
        reset = rst; cu_if.IR = ir; cu_if.Aeq0 = a0; cu_if.Apos = ap; cu_if.Enter = en;
        #1;
        check(name, got_word(), exp);
        @(posedge clk);
        ref_st = ref_next(ref_st, rst, ir, en);
    endtask

    task automatic mstep(input logic rst, input logic [2:0] ir, input logic a0,
                         input logic ap, input logic en, input string name);
        step(rst, ir, a0, ap, en, ref_out(ref_st, rst, en, a0, ap), name);
    endtask

    int aload_cnt;
    logic en_r;

    initial begin
        cu_if.IR = 3'b000; cu_if.Aeq0 = 1'b0; cu_if.Apos = 1'b0; cu_if.Enter = 1'b0;

        // Table: STORE, JZ taken / not taken, JPOS, SUB, ADD, LOAD.
        tbl.push_back('{1'b1, 3'b001, 1'b0, 1'b0, 1'b0, w(0,0,0,0,0,0,0,2'b00,0,4'd0),  "in_reset"});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 1'b0, 1'b0, w(0,0,0,0,0,0,0,2'b00,0,4'd0),  "start"});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 1'b0, 1'b0, w(1,0,1,0,0,0,0,2'b00,0,4'd1),  "fetch"});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 1'b0, 1'b0, w(0,0,0,1,0,0,0,2'b00,0,4'd2),  "decode_store"});
        tbl.push_back('{1'b0, 3'b001, 1'b0, 1'b0, 1'b0, w(0,0,0,1,1,0,0,2'b00,0,4'd4),  "store"});
        tbl.push_back('{1'b0, 3'b101, 1'b0, 1'b0, 1'b0, w(1,0,1,0,0,0,0,2'b00,0,4'd1),  "fetch2"});
        tbl.push_back('{1'b0, 3'b101, 1'b0, 1'b0, 1'b0, w(0,0,0,1,0,0,0,2'b00,0,4'd2),  "decode_jz"});
        tbl.push_back('{1'b0, 3'b101, 1'b1, 1'b0, 1'b0, w(0,1,1,0,0,0,0,2'b00,0,4'd9),  "jz_taken"});
        tbl.push_back('{1'b0, 3'b101, 1'b0, 1'b0, 1'b0, w(1,0,1,0,0,0,0,2'b00,0,4'd1),  "fetch3"});
        tbl.push_back('{1'b0, 3'b101, 1'b1, 1'b0, 1'b0, w(0,0,0,1,0,0,0,2'b00,0,4'd2),  "decode_jz_a0hi"});
        tbl.push_back('{1'b0, 3'b101, 1'b0, 1'b0, 1'b0, w(0,1,0,0,0,0,0,2'b00,0,4'd9),  "jz_not_taken"});
        tbl.push_back('{1'b0, 3'b110, 1'b0, 1'b0, 1'b0, w(1,0,1,0,0,0,0,2'b00,0,4'd1),  "fetch4"});
        tbl.push_back('{1'b0, 3'b110, 1'b0, 1'b0, 1'b0, w(0,0,0,1,0,0,0,2'b00,0,4'd2),  "decode_jpos"});
        tbl.push_back('{1'b0, 3'b110, 1'b0, 1'b1, 1'b0, w(0,1,1,0,0,0,0,2'b00,0,4'd10), "jpos_taken"});
        tbl.push_back('{1'b0, 3'b011, 1'b0, 1'b0, 1'b0, w(1,0,1,0,0,0,0,2'b00,0,4'd1),  "fetch5"});
        tbl.push_back('{1'b0, 3'b011, 1'b0, 1'b0, 1'b0, w(0,0,0,1,0,0,0,2'b00,0,4'd2),  "decode_sub"});
        tbl.push_back('{1'b0, 3'b011, 1'b0, 1'b0, 1'b0, w(0,0,0,1,0,1,1,2'b00,0,4'd6),  "sub"});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, w(1,0,1,0,0,0,0,2'b00,0,4'd1),  "fetch6"});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, w(0,0,0,1,0,0,0,2'b00,0,4'd2),  "decode_add"});
        tbl.push_back('{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, w(0,0,0,1,0,1,0,2'b00,0,4'd5),  "add"});
        tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, w(1,0,1,0,0,0,0,2'b00,0,4'd1),  "fetch7"});
        tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, w(0,0,0,1,0,0,0,2'b00,0,4'd2),  "decode_load"});
        tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, w(0,0,0,1,0,1,0,2'b10,0,4'd3),  "load"});
        tbl.push_back('{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, w(1,0,1,0,0,0,0,2'b00,0,4'd1),  "fetch8"});

        foreach (tbl[i])
            step(tbl[i].rst, tbl[i].ir, tbl[i].a0, tbl[i].ap, tbl[i].en, tbl[i].exp, tbl[i].name);

        // IN: Enter low 5 cycles, high 3, then low; one Aload pulse, back to FETCH.
        mstep(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "decode_in");
        aload_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            mstep(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "in_wait");
            aload_cnt += int'(cu_if.Aload);
        end
        for (int i = 0; i < 3; i++) begin
            mstep(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, "in_press");
            aload_cnt += int'(cu_if.Aload);
        end
        mstep(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "inrel_release");
        aload_cnt += int'(cu_if.Aload);
        step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, w(1,0,1,0,0,0,0,2'b00,0,4'd1), "in_back_to_fetch");
        check("aload_pulses", 14'(aload_cnt), 14'd1);

        // HALT holds with IR/Enter toggling, released only by Reset.
        mstep(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, "decode_halt");
        for (int i = 0; i < 10; i++)
            step(1'b0, 3'(i), i[0], i[1], i[0], w(0,0,0,0,0,0,0,2'b00,1,4'd11), "halt_hold");
        step(1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 14'd0, "halt_reset");
        step(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 14'd0, "after_halt_start");

        // Reset during IN with Enter high: reset wins, Aload stays low.
        mstep(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "fetch_in2");
        mstep(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "decode_in2");
        mstep(1'b0, 3'b100, 1'b0, 1'b0, 1'b0, "in2_wait");
        step(1'b1, 3'b100, 1'b0, 1'b0, 1'b1, 14'd0, "in_reset_enter");
        step(1'b0, 3'b100, 1'b0, 1'b0, 1'b1, 14'd0, "in_reset_start");

        // Randomized run against the reference model plus invariants.
        en_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic r;
            r = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) en_r = ~en_r;
            mstep(r, 3'($urandom), 1'($urandom), 1'($urandom), en_r, "random");
            check("memwr_aload_excl", 14'(cu_if.MemWr & cu_if.Aload), 14'd0);
            check("irload_fetch_only", 14'(cu_if.IRload & (cu_if.State != 4'd1)), 14'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  in  1  single system clock; all state changes on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset.
REQ-003 IR  in  3  opcode field from the datapath instruction register.
REQ-004 Aeq0  in  1  datapath flag, A == 0.
REQ-005 Apos  in  1  datapath flag, A > 0 (sign bit clear, nonzero).
REQ-006 Enter  in  1  user input-ready strobe, level, synchronous to Clock.
REQ-007 IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub  out  1 each  datapath controls.
REQ-008 Asel  out  2  A-mux select: 00 adder/subtractor, 01 INPUT, 10 memory data.
REQ-009 Halt  out  1  high while in HALT.
REQ-010 State  out  4  current state code, for debug display.

Function
REQ-011 Opcodes SHALL decode as: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 IN, 101 JZ, 110 JPOS, 111 HALT.
REQ-012 States SHALL be START=0, FETCH=1, DECODE=2, LOAD=3, STORE=4, ADD=5, SUB=6, IN=7, INREL=8, JZ=9, JPOS=10, HALT=11.
REQ-013 Outputs SHALL be combinational from the state register (plus Enter/Aeq0/Apos where stated); unlisted controls are 0, Asel defaults to 00.
REQ-014 START: all controls 0; next state FETCH.
REQ-015 FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0; next state DECODE.
REQ-016 DECODE: Meminst=1; next state selected by IR per REQ-011.
REQ-017 LOAD: Meminst=1, Aload=1, Asel=10; next state FETCH.
REQ-018 STORE: Meminst=1, MemWr=1; next state FETCH.
REQ-019 ADD: Meminst=1, Aload=1, Asel=00, Sub=0; SUB identical with Sub=1; next state FETCH.
REQ-020 IN: Asel=01, Aload=Enter; stays in IN while Enter=0; on Enter=1 goes to INREL.
REQ-021 INREL: all controls 0; stays while Enter=1; goes to FETCH when Enter=0 (one input consumed per press).
REQ-022 JZ: JMPmux=1, PCload=Aeq0; JPOS: JMPmux=1, PCload=Apos; next state FETCH.
REQ-023 HALT: all controls 0, Halt=1; stays in HALT until Reset.
REQ-024 Non-IN instructions SHALL take exactly 3 cycles (FETCH, DECODE, execute).
REQ-025 MemWr and Aload SHALL never be high in the same cycle; IRload only in FETCH.
REQ-026 Aeq0/Apos SHALL be sampled in the JZ/JPOS cycle, not at DECODE.

Reset
REQ-027 Reset=1 at a rising edge SHALL force state START regardless of current state, including mid-IN or HALT.
REQ-028 During and after reset, before the next edge, all controls SHALL be 0, Halt=0, State=0.
REQ-029 Reset SHALL take priority over every transition, including Enter.

Structure
REQ-030 Opcode constants, state encodings and Asel encodings SHALL live in shared package cu_pkg, also used by the datapath and benches.
REQ-031 Single module, one state register plus next-state/output logic; no sub-module is natural.

Verification
REQ-032 Reset, then IR=001 -> START, FETCH (IRload=PCload=1), DECODE (Meminst=1), STORE (MemWr=1, Meminst=1), FETCH; State 0,1,2,4,1.
REQ-033 IR=100, Enter held 0 for 5 cycles then 1 for 3 then 0 -> IN for 5 cycles, Aload=1 exactly one cycle, INREL 3 cycles, then FETCH.
REQ-034 IR=101 with Aeq0=1 -> JZ cycle JMPmux=1, PCload=1; repeat with Aeq0=0 -> PCload=0; both return to FETCH.
REQ-035 IR=110 with Apos=1 -> PCload=1; IR=011 -> SUB cycle Sub=1, Aload=1, Asel=00.
REQ-036 IR=111 -> HALT, Halt=1 held 10 cycles with IR/Enter toggling; Reset=1 -> START next edge, Halt=0.
REQ-037 Reset asserted during IN with Enter=1 -> next state START, Aload=0 after the edge.
